// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg7_pkg
// Brief    : Shared constants for the 7-segment scan controller: segment bit
//            positions and the active-high hex glyph table with its lookup.
// Revision : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Active-high {g,f,e,d,c,b,a} glyphs for 0-9, A, b, C, d, E, F
    localparam logic [6:0] HEX_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return HEX_TABLE[nibble];
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_hex_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seg7_hex_decoder
// Brief    : Combinational nibble to active-high 7-segment pattern {g..a}.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = hex_to_seg(i_nibble);

endmodule
`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_ctrl
// Brief    : Multiplexed 7-segment scanner with internal prescaler, per-frame
//            snapshot, blink mask, PWM brightness and raw-segment bypass.
//            Optional leading-zero blanking when SEG7_LZB_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int   DIGITS            = 8,
    parameter logic SEG_POLARITY      = 1'b0,
    parameter logic AN_POLARITY       = 1'b0,
    parameter int   SCAN_DIV_LOG2     = 10,
    parameter int   PWM_BITS          = 4,
    parameter int   BLINK_FRAMES_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIGITS*4-1:0]   data,
    input  logic [DIGITS-1:0]     point,
    input  logic [DIGITS-1:0]     en,
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic                  raw_mode,
    input  logic [DIGITS*8-1:0]   raw_seg,
    input  logic [PWM_BITS-1:0]   brightness,
    output logic [7:0]            segment,
    output logic [DIGITS-1:0]     anode,
    output logic                  frame_sync
);

    localparam int             IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    // Scan state
    logic [SCAN_DIV_LOG2-1:0]     r_presc;
    logic [IDX_W-1:0]             r_idx;
    logic [BLINK_FRAMES_LOG2-1:0] r_frame_cnt;
    logic                         r_blink_phase;

    // Frame snapshot
    logic [DIGITS*4-1:0]          r_data_s;
    logic [DIGITS-1:0]            r_point_s;
    logic [DIGITS-1:0]            r_en_s;
    logic [DIGITS-1:0]            r_blink_mask_s;
    logic                         r_raw_mode_s;
    logic [DIGITS*8-1:0]          r_raw_seg_s;
    logic [PWM_BITS-1:0]          r_brightness_s;

    // Output registers
    logic [7:0]                   r_segment;
    logic [DIGITS-1:0]            r_anode;
    logic                         r_frame_sync;

    logic                         w_frame_start;
    logic                         w_presc_last;
    logic [BLINK_FRAMES_LOG2-1:0] w_frame_cnt_next;
    logic                         w_blink_phase_next;

    logic [DIGITS*4-1:0]          w_data_cur;
    logic [DIGITS-1:0]            w_point_cur;
    logic [DIGITS-1:0]            w_en_cur;
    logic [DIGITS-1:0]            w_blink_mask_cur;
    logic                         w_raw_mode_cur;
    logic [DIGITS*8-1:0]          w_raw_seg_cur;
    logic [PWM_BITS-1:0]          w_brightness_cur;
    logic                         w_blink_phase_cur;

    logic [3:0]                   w_nibble;
    logic                         w_point_sel;
    logic                         w_en_sel;
    logic                         w_blink_sel;
    logic [7:0]                   w_raw_sel;
    logic [6:0]                   w_hex_seg;
    logic [7:0]                   w_pattern;
    logic                         w_lz_blank;
    logic                         w_vis;
    logic                         w_pwm_on;
    logic                         w_anode_on;
    logic [DIGITS-1:0]            w_onehot;

    assign w_frame_start      = (r_presc == '0) && (r_idx == '0);
    assign w_presc_last       = &r_presc;
    assign w_frame_cnt_next   = r_frame_cnt + 1'b1;
    assign w_blink_phase_next = r_blink_phase ^ (w_frame_cnt_next == '0);

    // The frame-start cycle itself already displays the newly captured
    // values, so the snapshot is bypassed for that one cycle.
    assign w_data_cur        = w_frame_start ? data       : r_data_s;
    assign w_point_cur       = w_frame_start ? point      : r_point_s;
    assign w_en_cur          = w_frame_start ? en         : r_en_s;
    assign w_blink_mask_cur  = w_frame_start ? blink_mask : r_blink_mask_s;
    assign w_raw_mode_cur    = w_frame_start ? raw_mode   : r_raw_mode_s;
    assign w_raw_seg_cur     = w_frame_start ? raw_seg    : r_raw_seg_s;
    assign w_brightness_cur  = w_frame_start ? brightness : r_brightness_s;
    assign w_blink_phase_cur = w_frame_start ? w_blink_phase_next : r_blink_phase;

    always_comb begin
        w_nibble    = '0;
        w_point_sel = 1'b0;
        w_en_sel    = 1'b0;
        w_blink_sel = 1'b0;
        w_raw_sel   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nibble    = w_data_cur[i*4 +: 4];
                w_point_sel = w_point_cur[i];
                w_en_sel    = w_en_cur[i];
                w_blink_sel = w_blink_mask_cur[i];
                w_raw_sel   = w_raw_seg_cur[i*8 +: 8];
            end
        end
    end

    seg7_hex_decoder u_hex_dec (
        .i_nibble (w_nibble),
        .o_seg    (w_hex_seg)
    );

    always_comb begin
        if (w_raw_mode_cur) begin
            w_pattern = w_raw_sel;
        end else begin
            w_pattern         = {1'b0, w_hex_seg};
            w_pattern[SEG_DP] = w_point_sel;
        end
    end

`ifdef SEG7_LZB_EN
    logic [DIGITS-1:0] w_lz;

    // w_lz[i] is set when digits i..DIGITS-1 carry neither a value nor a point
    always_comb begin
        logic v_acc;
        v_acc = 1'b1;
        w_lz  = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            v_acc   = v_acc & (w_data_cur[i*4 +: 4] == 4'h0) & ~w_point_cur[i];
            w_lz[i] = v_acc;
        end
    end

    always_comb begin
        w_lz_blank = 1'b0;
        for (int i = 1; i < DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_lz_blank = w_lz[i] & ~w_raw_mode_cur;
            end
        end
    end
`else
    assign w_lz_blank = 1'b0;
`endif

    assign w_vis      = w_en_sel & ~(w_blink_sel & w_blink_phase_cur) & ~w_lz_blank;
    assign w_pwm_on   = (w_brightness_cur == '1) |
                        (r_presc[SCAN_DIV_LOG2-1 -: PWM_BITS] < w_brightness_cur);
    assign w_onehot   = {{(DIGITS-1){1'b0}}, 1'b1} << r_idx;
    // Last cycle of every slot is a dead cycle against ghosting
    assign w_anode_on = w_vis & w_pwm_on & ~w_presc_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc       <= '0;
            r_idx         <= '0;
            r_frame_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else begin
            r_presc <= r_presc + 1'b1;
            if (w_presc_last) begin
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end
            if (w_frame_start) begin
                r_frame_cnt   <= w_frame_cnt_next;
                r_blink_phase <= w_blink_phase_next;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_s       <= '0;
            r_point_s      <= '0;
            r_en_s         <= '0;
            r_blink_mask_s <= '0;
            r_raw_mode_s   <= 1'b0;
            r_raw_seg_s    <= '0;
            r_brightness_s <= '0;
        end else if (w_frame_start) begin
            r_data_s       <= data;
            r_point_s      <= point;
            r_en_s         <= en;
            r_blink_mask_s <= blink_mask;
            r_raw_mode_s   <= raw_mode;
            r_raw_seg_s    <= raw_seg;
            r_brightness_s <= brightness;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_segment    <= {8{~SEG_POLARITY}};
            r_anode      <= {DIGITS{~AN_POLARITY}};
            r_frame_sync <= 1'b0;
        end else begin
            r_segment    <= w_pattern ^ {8{~SEG_POLARITY}};
            r_anode      <= (w_anode_on ? w_onehot : '0) ^ {DIGITS{~AN_POLARITY}};
            r_frame_sync <= w_frame_start;
        end
    end

    assign segment    = r_segment;
    assign anode      = r_anode;
    assign frame_sync = r_frame_sync;

endmodule
`default_nettype wire
